// File: rtl/io_mem_responder_pkg.sv
// Shared types and constants for the IO memory responder.
package io_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
    } state_e;

    localparam logic [3:0]  IO_BASE_NIBBLE = 4'hF;
    localparam logic [31:0] IO_ERR_RDATA   = 32'hDEAD_BEEF;
    localparam int          NUM_LANES      = 4;

    // Outside the IO window, or a halfword/word access that is not naturally aligned.
    function automatic logic addr_bad(logic [31:0] addr, logic [3:0] wen);
        return (addr[31:28] != IO_BASE_NIBBLE) ||
               (wen == 4'b0011 && addr[0]) ||
               (wen == 4'b1111 && addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/io_mem_responder_ram.sv
// Byte-addressed DEPTHx8 store with four byte lanes; lane indices wrap modulo DEPTH.
module io_mem_responder_ram
    import io_mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_LANES-1:0]   we,
    input  logic                   re,
    input  logic [AW-1:0]          addr,
    input  logic [8*NUM_LANES-1:0] wdata,
    output logic [8*NUM_LANES-1:0] rdata
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] idx [NUM_LANES];

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++)
            idx[i] = addr + AW'(i);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++)
            if (we[i]) mem[idx[i]] <= wdata[8*i +: 8];
    end

    // Read port returns zero except in the cycle after a read is accepted.
    always_ff @(posedge clk) begin
        if (rst || !re) begin
            rdata <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++)
                rdata[8*i +: 8] <= mem[idx[i]];
        end
    end

endmodule

// File: rtl/io_mem_responder.sv
// IO request bus target: single outstanding access, ACK_DELAY wait states, one-cycle completion.
// Optional address/alignment checking enabled by defining IO_MEM_RESPONDER_ADDR_CHECK_EN.
module io_mem_responder
    import io_mem_responder_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int ACK_DELAY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_req,
    input  logic        io_wr,
    input  logic [3:0]  io_wen,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    output logic        io_req_ack,
    output logic [31:0] io_rdata,
    output logic        io_data_ack,
    output logic        io_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] ACK_LOAD = (ACK_DELAY == 0) ? 4'd0 : 4'(ACK_DELAY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        accept;
    logic        req_bad;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic        unused_addr;

    assign unused_addr = ^io_addr;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (io_req) state_d = (ACK_DELAY == 0) ? ST_DATA : ST_WAIT;
            ST_WAIT: begin
                if (!io_req)          state_d = ST_IDLE;
                else if (cnt_q == 0)  state_d = ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        io_req_ack  = 1'b0;
        io_data_ack = (state_q == ST_DATA);
        if (!rst) begin
            case (state_q)
                ST_IDLE: io_req_ack = (ACK_DELAY == 0) && io_req;
                ST_WAIT: io_req_ack = io_req && (cnt_q == 4'd0);
                default: io_req_ack = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                  cnt_q <= 4'd0;
        else if (state_q == ST_IDLE && io_req)    cnt_q <= ACK_LOAD;
        else if (state_q == ST_WAIT && cnt_q != 0) cnt_q <= cnt_q - 4'd1;
    end

    assign accept = io_req && io_req_ack;

`ifdef IO_MEM_RESPONDER_ADDR_CHECK_EN
    logic err_q;
    logic bad_rd_q;

    assign req_bad = addr_bad(io_addr, io_wen);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= 1'b0;
            bad_rd_q <= 1'b0;
        end else begin
            bad_rd_q <= accept && !io_wr && req_bad;
            if (accept && req_bad) err_q <= 1'b1;
        end
    end

    assign io_err   = err_q;
    assign io_rdata = bad_rd_q ? IO_ERR_RDATA : ram_rdata;
`else
    assign req_bad  = 1'b0;
    assign io_err   = 1'b0;
    assign io_rdata = ram_rdata;
`endif

    assign ram_we = (accept && io_wr && !req_bad) ? io_wen : 4'b0000;
    assign ram_re = accept && !io_wr && !req_bad;

    io_mem_responder_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (io_addr[AW-1:0]),
        .wdata (io_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_io_mem_responder.sv
// Randomized bench for io_mem_responder: two instances (ACK_DELAY 0 and 3) against a byte-array model.
module tb_io_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, req, wr, req_ack, data_ack, err;
    logic [1:0][3:0]  wen;
    logic [1:0][31:0] addr, wdata, rdata;

    io_mem_responder #(.DEPTH(256), .ACK_DELAY(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .io_req(req[0]), .io_wr(wr[0]), .io_wen(wen[0]),
        .io_addr(addr[0]), .io_wdata(wdata[0]), .io_req_ack(req_ack[0]),
        .io_rdata(rdata[0]), .io_data_ack(data_ack[0]), .io_err(err[0]));

    io_mem_responder #(.DEPTH(256), .ACK_DELAY(3)) u_dut3 (
        .clk(clk), .rst(rst[1]), .io_req(req[1]), .io_wr(wr[1]), .io_wen(wen[1]),
        .io_addr(addr[1]), .io_wdata(wdata[1]), .io_req_ack(req_ack[1]),
        .io_rdata(rdata[1]), .io_data_ack(data_ack[1]), .io_err(err[1]));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem_m [2][256];
    bit         err_m [2];
    int         last_acc [2];

    function automatic int dly(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic bit is_bad(logic [31:0] a, logic [3:0] e);
`ifdef IO_MEM_RESPONDER_ADDR_CHECK_EN
        return (a[31:28] != 4'hF) || (e == 4'b0011 && a[0]) || (e == 4'b1111 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full transaction on instance k; model updated at the acceptance cycle.
    task automatic txn(input int k, input bit w, input logic [3:0] e,
                       input logic [31:0] a, input logic [31:0] d, input bit b2b);
        int          waited;
        bit          got, bd;
        logic [31:0] exp;
        logic [7:0]  ix;
        @(negedge clk);
        req[k] = 1'b1; wr[k] = w; wen[k] = e; addr[k] = a; wdata[k] = d;
        #1;
        chk("idle_dack", 32'(data_ack[k]), 32'd0);
        chk("idle_rdata", rdata[k], 32'd0);
        waited = 0;
        got    = req_ack[k];
        while (!got && waited < 40) begin
            @(negedge clk); #1;
            waited++;
            got = req_ack[k];
        end
        chk("ack_lat", waited, dly(k));
        if (!got) begin
            req[k] = 1'b0;
            return;
        end
        if (b2b) chk("spacing", cyc - last_acc[k], dly(k) + 2);
        last_acc[k] = cyc;
        bd  = is_bad(a, e);
        exp = 32'd0;
        for (int i = 0; i < 4; i++) begin
            ix = a[7:0] + 8'(i);
            if (w) begin
                if (!bd && e[i]) mem_m[k][ix] = d[8*i +: 8];
            end else begin
                exp[8*i +: 8] = mem_m[k][ix];
            end
        end
        if (!w && bd) exp = 32'hDEAD_BEEF;
        if (bd) err_m[k] = 1'b1;
        @(negedge clk);
        req[k] = 1'b0;
        #1;
        chk("dack", 32'(data_ack[k]), 32'd1);
        chk(w ? "wr_rdata" : "rd_rdata", rdata[k], exp);
        chk("data_phase_ack", 32'(req_ack[k]), 32'd0);
        chk("err", 32'(err[k]), 32'(err_m[k]));
    endtask

    initial begin
        rst = 2'b11; req = '0; wr = '0; wen = '0; addr = '0; wdata = '0;
        err_m[0] = 0; err_m[1] = 0; last_acc[0] = 0; last_acc[1] = 0;

        // Reset state, with a request pending to confirm the ack is suppressed.
        repeat (3) @(negedge clk);
        req = 2'b11;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ack", 32'(req_ack[k]), 32'd0);
            chk("rst_dack", 32'(data_ack[k]), 32'd0);
            chk("rst_rdata", rdata[k], 32'd0);
            chk("rst_err", 32'(err[k]), 32'd0);
        end
        req = 2'b00;
        @(negedge clk);
        rst = 2'b00;

        // Fill both memories so every later read has a defined expectation.
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 64; w++)
                txn(k, 1'b1, 4'b1111, 32'hF000_0000 | 32'(w * 4), $urandom, 1'b0);

        // Directed cases.
        txn(0, 1'b1, 4'b1111, 32'hF000_0010, 32'h1122_3344, 1'b0);
        txn(0, 1'b0, 4'b1111, 32'hF000_0010, 32'h0, 1'b0);
        txn(0, 1'b1, 4'b0001, 32'hF000_0011, 32'h0000_00AA, 1'b0);
        txn(0, 1'b0, 4'b1111, 32'hF000_0010, 32'h0, 1'b0);
        txn(0, 1'b1, 4'b1111, 32'hF000_00FE, 32'hCAFE_F00D, 1'b0);
        txn(0, 1'b0, 4'b1111, 32'hF000_00FE, 32'h0, 1'b0);
        txn(0, 1'b0, 4'b1111, 32'hF000_0000, 32'h0, 1'b0);
        txn(0, 1'b1, 4'b0000, 32'hF000_0020, 32'hFFFF_FFFF, 1'b0);
        txn(0, 1'b0, 4'b1111, 32'hF000_0020, 32'h0, 1'b0);
        txn(0, 1'b0, 4'b1111, 32'h1000_0000, 32'h0, 1'b0);
        txn(0, 1'b1, 4'b1111, 32'hF000_0002, 32'h5555_AAAA, 1'b0);
        txn(0, 1'b0, 4'b1111, 32'hF000_0000, 32'h0, 1'b0);
        txn(0, 1'b0, 4'b1111, 32'hF000_0004, 32'h0, 1'b0);

        // Back-to-back throughput on both instances.
        for (int k = 0; k < 2; k++) begin
            txn(k, 1'b0, 4'b1111, 32'hF000_0040, 32'h0, 1'b0);
            for (int j = 0; j < 3; j++)
                txn(k, 1'b0, 4'b1111, 32'hF000_0000 | 32'($urandom_range(63, 0) * 4), 32'h0, 1'b1);
        end

        // Request withdrawn while waiting: no access, FSM back to idle.
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b0; wen[1] = 4'b1111; addr[1] = 32'hF000_0008;
        @(negedge clk); #1;
        chk("wait_no_ack", 32'(req_ack[1]), 32'd0);
        req[1] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); #1;
            chk("abort_no_dack", 32'(data_ack[1]), 32'd0);
        end
        txn(1, 1'b0, 4'b1111, 32'hF000_0008, 32'h0, 1'b0);

        // Reset during the completion cycle.
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b0; wen[0] = 4'b1111; addr[0] = 32'hF000_0010;
        #1;
        chk("rstd_ack", 32'(req_ack[0]), 32'd1);
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        chk("rstd_dack_before", 32'(data_ack[0]), 32'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        err_m[0] = 1'b0;
        #1;
        chk("rstd_dack", 32'(data_ack[0]), 32'd0);
        chk("rstd_rdata", rdata[0], 32'd0);
        chk("rstd_err", 32'(err[0]), 32'd0);
        txn(0, 1'b0, 4'b1111, 32'hF000_0010, 32'h0, 1'b0);

        // Randomized mix across both instances.
        for (int n = 0; n < 250; n++) begin
            int          k;
            bit          w;
            logic [31:0] a;
            logic [3:0]  e;
            k = int'($urandom_range(1, 0));
            w = 1'($urandom_range(1, 0));
            a = $urandom;
            if ($urandom_range(7, 0) != 0) a[31:28] = 4'hF;
            case ($urandom_range(3, 0))
                0:       e = 4'b1111;
                1:       e = 4'b0011;
                default: e = 4'($urandom);
            endcase
            txn(k, w, e, a, $urandom, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
